mhd_sweep_ctrl: RTL and testbench

- Sequencer for the max-Hamming-distance check between an exact output word `a` and an approximate output word `b`.
- Accepts a run of `num_vec` vector pairs over a valid/ready handshake and computes `popcount(a^b)` per pair through a 2-stage pipeline.
- Accumulates run statistics: error count (distance > MHD), maximum distance, and the index of the first failure.
- Used by the approximation-evaluation flow to sweep a vector set against one MHD bound and report pass/fail.

---
 rtl/mhd_sweep_ctrl.sv | 159 +++++++++++++++
 tb/tb_mhd_sweep_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mhd_sweep_ctrl.sv
// Max-Hamming-distance sweep sequencer: streams a/b pairs through a 2-stage
// popcount pipeline and accumulates per-run error count, max distance, first failure.
module mhd_sweep_ctrl #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned MHD   = 1,
  parameter int unsigned NUM_W = 16,
  localparam int unsigned HD_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] num_vec,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [NUM_W-1:0] err_cnt,
  output logic [HD_W-1:0]  max_hd,
  output logic [NUM_W-1:0] first_fail_idx
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [NUM_W-1:0] num_vec_q, num_vec_d;
  logic [NUM_W-1:0] idx_q, idx_d;
  logic             s1_valid_q, s1_valid_d;
  logic [HD_W-1:0]  s1_hd_q, s1_hd_d;
  logic [NUM_W-1:0] s1_idx_q, s1_idx_d;
  logic             fail_q, fail_d;
  logic [NUM_W-1:0] err_cnt_q, err_cnt_d;
  logic [HD_W-1:0]  max_hd_q, max_hd_d;
  logic [NUM_W-1:0] ffi_q, ffi_d;

  logic [WIDTH-1:0] diff;
  logic [HD_W-1:0]  hd_calc;
  logic             accept;
  logic             start_ok;
  logic             last_pair;
  logic             s2_err;

  assign diff = a ^ b;

  always_comb begin
    hd_calc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      hd_calc = hd_calc + HD_W'(diff[i]);
    end
  end

  assign in_ready  = (state_q == StRun);
  assign busy      = (state_q == StRun) || (state_q == StDrain);
  assign done      = (state_q == StDone);
  assign accept    = in_valid && in_ready;
  assign start_ok  = start && ((state_q == StIdle) || (state_q == StDone));
  assign last_pair = (idx_q == num_vec_q - NUM_W'(1));
  assign s2_err    = s1_valid_q && (32'(s1_hd_q) > MHD);

  // Front end: FSM, pair index and stage 1
  always_comb begin
    state_d    = state_q;
    num_vec_d  = num_vec_q;
    idx_d      = idx_q;
    s1_valid_d = 1'b0;
    s1_hd_d    = s1_hd_q;
    s1_idx_d   = s1_idx_q;
    case (state_q)
      StIdle, StDone: begin
        if (start_ok) begin
          num_vec_d = num_vec;
          idx_d     = '0;
          state_d   = (num_vec != '0) ? StRun : StDone;
        end
      end
      StRun: begin
        if (accept) begin
          s1_valid_d = 1'b1;
          s1_hd_d    = hd_calc;
          s1_idx_d   = idx_q;
          idx_d      = idx_q + NUM_W'(1);
          if (last_pair) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        state_d = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Stage 2: statistics; a run start wins over any stage-2 update
  always_comb begin
    fail_d    = fail_q;
    err_cnt_d = err_cnt_q;
    max_hd_d  = max_hd_q;
    ffi_d     = ffi_q;
    if (start_ok) begin
      fail_d    = 1'b0;
      err_cnt_d = '0;
      max_hd_d  = '0;
      ffi_d     = '0;
    end else if (s1_valid_q) begin
      if (s2_err) begin
        if (err_cnt_q != '1) begin
          err_cnt_d = err_cnt_q + NUM_W'(1);
        end
        if (!fail_q) begin
          fail_d = 1'b1;
          ffi_d  = s1_idx_q;
        end
      end
      if (s1_hd_q > max_hd_q) begin
        max_hd_d = s1_hd_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      num_vec_q  <= '0;
      idx_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_hd_q    <= '0;
      s1_idx_q   <= '0;
      fail_q     <= 1'b0;
      err_cnt_q  <= '0;
      max_hd_q   <= '0;
      ffi_q      <= '0;
    end else begin
      state_q    <= state_d;
      num_vec_q  <= num_vec_d;
      idx_q      <= idx_d;
      s1_valid_q <= s1_valid_d;
      s1_hd_q    <= s1_hd_d;
      s1_idx_q   <= s1_idx_d;
      fail_q     <= fail_d;
      err_cnt_q  <= err_cnt_d;
      max_hd_q   <= max_hd_d;
      ffi_q      <= ffi_d;
    end
  end

  assign fail           = fail_q;
  assign err_cnt        = err_cnt_q;
  assign max_hd         = max_hd_q;
  assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_mhd_sweep_ctrl.sv
// Self-checking bench for mhd_sweep_ctrl: table-driven runs with a per-pair
// scoreboard, plus hand-written reset, zero-length and saturation sequences.
module tb_mhd_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num_vec = '0;
  logic        in_valid = 1'b0;
  logic [8:0]  a = '0;
  logic [8:0]  b = '0;
  logic        sel = 1'b0;

  logic        rdy16, busy16, done16, fail16;
  logic [15:0] err16, ffi16;
  logic [3:0]  max16;
  logic        rdy4, busy4, done4, fail4;
  logic [3:0]  err4, ffi4;
  logic [3:0]  max4;

  always #5 clk = ~clk;

  mhd_sweep_ctrl #(.WIDTH(9), .MHD(1), .NUM_W(16)) u_dut (
    .clk(clk), .rst(rst), .start(start), .num_vec(num_vec), .in_valid(in_valid),
    .in_ready(rdy16), .a(a), .b(b), .busy(busy16), .done(done16), .fail(fail16),
    .err_cnt(err16), .max_hd(max16), .first_fail_idx(ffi16)
  );

  mhd_sweep_ctrl #(.WIDTH(9), .MHD(1), .NUM_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .num_vec(num_vec[3:0]), .in_valid(in_valid),
    .in_ready(rdy4), .a(a), .b(b), .busy(busy4), .done(done4), .fail(fail4),
    .err_cnt(err4), .max_hd(max4), .first_fail_idx(ffi4)
  );

  wire        rdy_m  = sel ? rdy4 : rdy16;
  wire        busy_m = sel ? busy4 : busy16;
  wire        done_m = sel ? done4 : done16;
  wire        fail_m = sel ? fail4 : fail16;
  wire [15:0] err_m  = sel ? {12'b0, err4} : err16;
  wire [15:0] ffi_m  = sel ? {12'b0, ffi4} : ffi16;
  wire [3:0]  max_m  = sel ? max4 : max16;

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboard entries: {pair index, distance}
  int q[$];
  int m_idx, m_err, m_max, m_ffi;
  bit m_fail;

  typedef struct packed {
    logic [15:0]      nv;
    logic [4:0]       np;
    logic [3:0]       gap;
    logic [15:0][8:0] pa;
    logic [15:0][8:0] pb;
    logic             e_fail;
    logic [15:0]      e_err;
    logic [3:0]       e_max;
    logic [15:0]      e_ffi;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_idx = 0; m_err = 0; m_max = 0; m_ffi = 0; m_fail = 1'b0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_fail"}, int'(fail_m), int'(m_fail));
    chk({tag, "_err_cnt"}, int'(err_m), m_err);
    chk({tag, "_max_hd"}, int'(max_m), m_max);
    chk({tag, "_first_fail_idx"}, int'(ffi_m), m_ffi);
  endtask

  task automatic step(output bit acc);
    bit pre_acc, pre_start;
    int e, hd, sat;
    pre_acc   = in_valid && rdy_m && !rst;
    pre_start = start && !busy_m && !rst;
    hd        = $countones(a ^ b);
    sat       = sel ? 15 : 65535;
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      model_clear();
    end else begin
      if (q.size() > 0) begin
        e = q.pop_front();
        if ((e & 15) > 1) begin
          if (m_err != sat) m_err++;
          if (!m_fail) begin
            m_fail = 1'b1;
            m_ffi  = e >> 4;
          end
        end
        if ((e & 15) > m_max) m_max = e & 15;
        check_model("pair");
      end
      if (pre_start) model_clear();
      if (pre_acc) begin
        q.push_back((m_idx << 4) | hd);
        m_idx++;
      end
    end
    acc = pre_acc;
  endtask

  task automatic check_final(input vec_t v, input string tag);
    chk({tag, "_fail"}, int'(fail_m), int'(v.e_fail));
    chk({tag, "_err_cnt"}, int'(err_m), int'(v.e_err));
    chk({tag, "_max_hd"}, int'(max_m), int'(v.e_max));
    chk({tag, "_first_fail_idx"}, int'(ffi_m), int'(v.e_ffi));
  endtask

  task automatic run_entry(input vec_t v, input bit poke_start);
    bit acc;
    int n;
    start = 1'b1;
    num_vec = v.nv;
    step(acc);
    start = 1'b0;
    chk("busy_after_start", int'(busy_m), 1);
    chk("done_after_start", int'(done_m), 0);
    check_model("cleared");
    for (int p = 0; p < int'(v.np); p++) begin
      a = v.pa[p];
      b = v.pb[p];
      in_valid = 1'b1;
      n = 0;
      acc = 1'b0;
      while (!acc && n < 50) begin
        if (poke_start && p == 5 && n == 0) start = 1'b1;
        step(acc);
        start = 1'b0;
        n++;
      end
      if (!acc) chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      if (p != int'(v.np) - 1) begin
        for (int g = 0; g < int'(v.gap); g++) begin
          chk("in_ready_gap", int'(rdy_m), 1);
          step(acc);
        end
      end
    end
    chk("drain_done", int'(done_m), 0);
    chk("drain_busy", int'(busy_m), 1);
    chk("drain_ready", int'(rdy_m), 0);
    step(acc);
    chk("done_level", int'(done_m), 1);
    chk("done_busy", int'(busy_m), 0);
    check_final(v, "final");
    in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      a = 9'($urandom);
      b = 9'($urandom);
      step(acc);
      chk("no_accept_in_done", int'(acc), 0);
    end
    in_valid = 1'b0;
    chk("done_hold", int'(done_m), 1);
    check_final(v, "stable");
  endtask

  initial begin
    bit acc;
    model_clear();

    tbl[0] = '0;
    tbl[0].nv = 16'd4; tbl[0].np = 5'd4; tbl[0].gap = 4'd0;
    tbl[0].pa[0] = 9'h1FF; tbl[0].pb[0] = 9'h1FF;
    tbl[0].pa[1] = 9'h000; tbl[0].pb[1] = 9'h001;
    tbl[0].pa[2] = 9'h0F0; tbl[0].pb[2] = 9'h0F0;
    tbl[0].pa[3] = 9'h100; tbl[0].pb[3] = 9'h000;
    tbl[0].e_fail = 1'b0; tbl[0].e_err = 16'd0; tbl[0].e_max = 4'd1; tbl[0].e_ffi = 16'd0;

    tbl[1] = '0;
    tbl[1].nv = 16'd3; tbl[1].np = 5'd3; tbl[1].gap = 4'd2;
    tbl[1].pa[0] = 9'h000; tbl[1].pb[0] = 9'h003;
    tbl[1].pa[1] = 9'h000; tbl[1].pb[1] = 9'h000;
    tbl[1].pa[2] = 9'h1FF; tbl[1].pb[2] = 9'h000;
    tbl[1].e_fail = 1'b1; tbl[1].e_err = 16'd2; tbl[1].e_max = 4'd9; tbl[1].e_ffi = 16'd0;

    tbl[2] = '0;
    tbl[2].nv = 16'd4; tbl[2].np = 5'd4; tbl[2].gap = 4'd1;
    tbl[2].pa[0] = 9'h000; tbl[2].pb[0] = 9'h000;
    tbl[2].pa[1] = 9'h000; tbl[2].pb[1] = 9'h001;
    tbl[2].pa[2] = 9'h000; tbl[2].pb[2] = 9'h006;
    tbl[2].pa[3] = 9'h000; tbl[2].pb[3] = 9'h1C0;
    tbl[2].e_fail = 1'b1; tbl[2].e_err = 16'd2; tbl[2].e_max = 4'd3; tbl[2].e_ffi = 16'd2;

    tbl[3] = '0;
    tbl[3].nv = 16'd1; tbl[3].np = 5'd1;
    tbl[3].pa[0] = 9'h000; tbl[3].pb[0] = 9'h007;
    tbl[3].e_fail = 1'b1; tbl[3].e_err = 16'd1; tbl[3].e_max = 4'd3; tbl[3].e_ffi = 16'd0;

    tbl[4] = '0;
    tbl[4].nv = 16'd1; tbl[4].np = 5'd1;
    tbl[4].pa[0] = 9'h0AA; tbl[4].pb[0] = 9'h0AA;
    tbl[4].e_fail = 1'b0; tbl[4].e_err = 16'd0; tbl[4].e_max = 4'd0; tbl[4].e_ffi = 16'd0;

    tbl[5] = '0;
    tbl[5].nv = 16'd15; tbl[5].np = 5'd15;
    for (int i = 0; i < 15; i++) begin
      tbl[5].pa[i] = 9'h000;
      tbl[5].pb[i] = 9'h1FF;
    end
    tbl[5].e_fail = 1'b1; tbl[5].e_err = 16'd15; tbl[5].e_max = 4'd9; tbl[5].e_ffi = 16'd0;

    // Reset with in_valid asserted: nothing may be consumed
    rst = 1'b1;
    in_valid = 1'b1;
    a = 9'h000;
    b = 9'h1FF;
    step(acc);
    step(acc);
    rst = 1'b0;
    step(acc);
    chk("reset_accept", int'(acc), 0);
    chk("reset_in_ready", int'(rdy_m), 0);
    chk("reset_done", int'(done_m), 0);
    chk("reset_busy", int'(busy_m), 0);
    check_final(tbl[4], "reset");
    in_valid = 1'b0;

    run_entry(tbl[0], 1'b0);
    run_entry(tbl[2], 1'b0);
    run_entry(tbl[1], 1'b0);

    // Zero-length run from DONE clears stats and stays done
    start = 1'b1;
    num_vec = 16'd0;
    step(acc);
    start = 1'b0;
    chk("zero_done", int'(done_m), 1);
    chk("zero_busy", int'(busy_m), 0);
    check_final(tbl[4], "zero");
    run_entry(tbl[3], 1'b0);

    // Reset mid-run discards in-flight pairs
    start = 1'b1;
    num_vec = 16'd5;
    step(acc);
    start = 1'b0;
    in_valid = 1'b1;
    a = 9'h000;
    b = 9'h003;
    step(acc);
    chk("mid_accept0", int'(acc), 1);
    b = 9'h1FF;
    step(acc);
    chk("mid_accept1", int'(acc), 1);
    in_valid = 1'b0;
    rst = 1'b1;
    step(acc);
    rst = 1'b0;
    chk("mid_rst_busy", int'(busy_m), 0);
    chk("mid_rst_done", int'(done_m), 0);
    chk("mid_rst_ready", int'(rdy_m), 0);
    check_final(tbl[4], "mid_rst");
    step(acc);
    check_final(tbl[4], "mid_rst_idle");
    run_entry(tbl[4], 1'b0);

    // Saturation corner on the 4-bit counter instance, with a start poked mid-run
    sel = 1'b1;
    run_entry(tbl[5], 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
